// File: rtl/rv32_bus_pkg.sv
// Shared definitions for the single-slave memory bus arbiter:
// default widths, master count, timeout default, FSM state type and a
// modulo-3 index helper used by the round-robin picker.
package rv32_bus_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int NUM_M       = 3;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Master index reached by stepping 'step' places after 'base', wrapping at NUM_M.
  function automatic logic [1:0] idx_after(input logic [1:0] base, input int step);
    return 2'((int'(base) + step) % NUM_M);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requesting master found
// searching upward from ptr+1 (mod 3) wins.
module rr_pick
  import rv32_bus_pkg::*;
(
  input  logic [NUM_M-1:0] req,
  input  logic [1:0]       ptr,
  output logic             valid,
  output logic [1:0]       idx
);

  // Scan from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    valid = |req;
    idx   = '0;
    for (int k = NUM_M; k >= 1; k--) begin
      if (req[idx_after(ptr, k)]) idx = idx_after(ptr, k);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Three-master, single-slave bus arbiter. One transaction outstanding:
// IDLE picks a master round-robin, ADDR forwards its request until the
// slave grants, RESP waits for the slave response or a timeout.
module mem_bus_arbiter
  import rv32_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_M-1:0]        m_req,
  input  logic [NUM_M-1:0]        m_we,
  input  logic [NUM_M*ADDR_W-1:0] m_addr,
  input  logic [NUM_M*DATA_W-1:0] m_wdata,
  input  logic [NUM_M*4-1:0]      m_wstrb,
  output logic [NUM_M-1:0]        m_gnt,
  output logic [NUM_M-1:0]        m_rvalid,
  output logic [DATA_W-1:0]       m_rdata,
  output logic [NUM_M-1:0]        m_err,
  output logic                    s_req,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  output logic [3:0]              s_wstrb,
  input  logic                    s_gnt,
  input  logic                    s_rvalid,
  input  logic [DATA_W-1:0]       s_rdata,
  output logic                    busy,
  output logic [1:0]              owner
);

  // Last wait-count value before the timeout fires; the count clears on
  // RESP entry, so with TIMEOUT=N a silent slave times out in RESP cycle N.
  localparam logic [7:0] L_CNT_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_owner;
  logic [7:0]       r_cnt;

  logic             w_pick_valid;
  logic [1:0]       w_pick_idx;
  logic [NUM_M-1:0] w_owner_oh;
  logic             w_timeout;

  rr_pick u_rr_pick (
    .req   (m_req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_owner_oh = 3'b001 << r_owner;
  // A response arriving in the final wait cycle takes precedence over the timeout.
  assign w_timeout  = (r_state == ST_RESP) && !s_rvalid && (r_cnt == L_CNT_LAST);

  // Transaction FSM: ownership, round-robin pointer and response wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd2;
      r_owner <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_owner <= w_pick_idx;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_gnt) begin
            r_cnt   <= 8'd0;
            r_state <= ST_RESP;
          end else if (!m_req[r_owner]) begin
            // Owner withdrew before acceptance: pointer stays put.
            r_state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (s_rvalid || w_timeout) begin
            r_ptr   <= r_owner;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Slave-side mux and master-side response routing, decoded from state.
  always_comb begin
    s_req    = 1'b0;
    s_we     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m_gnt    = '0;
    m_rvalid = '0;
    m_err    = '0;
    m_rdata  = '0;
    case (r_state)
      ST_ADDR: begin
        s_req   = 1'b1;
        s_we    = m_we[r_owner];
        s_addr  = m_addr[r_owner*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[r_owner*DATA_W +: DATA_W];
        s_wstrb = m_wstrb[r_owner*4 +: 4];
        m_gnt   = s_gnt ? w_owner_oh : '0;
      end
      ST_RESP: begin
        if (s_rvalid) begin
          m_rvalid = w_owner_oh;
          m_rdata  = s_rdata;
        end else if (w_timeout) begin
          m_rvalid = w_owner_oh;
          m_err    = w_owner_oh;
        end
      end
      default: ;
    endcase
  end

  assign busy  = (r_state != ST_IDLE);
  assign owner = r_owner;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum response-wait cycles, range 1..255.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  3  master request; [0]=data port, [1]=instruction fetch, [2]=loader/debug.
- m_we  in  3  per-master write enable.
- m_addr  in  3*ADDR_W  per-master address, master i at slice i.
- m_wdata  in  3*DATA_W  per-master write data.
- m_wstrb  in  3*4  per-master byte strobes.
- m_gnt  out  3  request accepted, one-hot.
- m_rvalid  out  3  response strobe, one-hot.
- m_rdata  out  DATA_W  response data, shared by all masters.
- m_err  out  3  timeout error, qualified by m_rvalid.
- s_req  out  1  slave request.
- s_we  out  1  slave write enable.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_wstrb  out  4  slave byte strobes.
- s_gnt  in  1  slave accepts request.
- s_rvalid  in  1  slave response valid.
- s_rdata  in  DATA_W  slave read data.
- busy  out  1  arbiter is not in IDLE.
- owner  out  2  index of the current owning master.
REQ-003 The block SHALL have one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, ADDR and RESP, with one transaction outstanding at a time.
REQ-005 In IDLE with any m_req bit high, the arbiter SHALL pick a master round-robin, starting at index ptr+1 mod 3, register it in owner, and enter ADDR on the next edge.
REQ-006 In ADDR, s_req SHALL be 1 and s_we/s_addr/s_wdata/s_wstrb SHALL mirror the owner's inputs combinationally; m_gnt[owner] SHALL equal s_gnt.
REQ-007 In ADDR:
- s_gnt=1 SHALL move the FSM to RESP.
- m_req[owner]=0 before s_gnt SHALL abort to IDLE with ptr unchanged and no m_rvalid.
REQ-008 In RESP:
- s_rvalid=1 SHALL give m_rvalid[owner]=1 and m_rdata=s_rdata for that cycle.
- The FSM SHALL then return to IDLE and set ptr=owner.
- Writes also complete through s_rvalid.
REQ-009 A wait counter SHALL clear on entry to RESP and increment each RESP cycle without s_rvalid; at count==TIMEOUT the block SHALL:
- pulse m_rvalid[owner] and m_err[owner];
- drive m_rdata=0;
- set ptr=owner and return to IDLE.
REQ-010 s_rvalid SHALL be ignored outside RESP; a late response after a timeout SHALL be dropped.
REQ-011 s_rvalid SHALL NOT be sampled in ADDR; the slave guarantees at least one cycle between s_gnt and s_rvalid.
REQ-012 Outside active states:
- s_* outputs SHALL be 0.
- m_rdata SHALL be 0 when no m_rvalid is asserted.
- busy SHALL be 1 in ADDR and RESP.
REQ-013 Latency from m_req to s_req SHALL be 1 cycle; back-to-back transactions SHALL take at least 3 cycles each (IDLE, ADDR, RESP).
REQ-014 m_req changes of non-owners SHALL NOT affect the transaction in progress.

Reset
REQ-015 Reset SHALL set state=IDLE, ptr=2 (first pick order 0,1,2), owner=0 and counter=0, with all outputs 0.
REQ-016 Reset asserted mid-transaction SHALL abandon it immediately with no m_rvalid.

Structure
REQ-017 Package rv32_bus_pkg SHALL hold:
- ADDR_W and DATA_W defaults;
- NUM_M=3;
- the FSM state enum;
- the default TIMEOUT.
REQ-018 Sub-module rr_pick SHALL be combinational: (req[2:0], ptr[1:0]) -> (valid, idx[1:0]); the FSM, counter and muxes SHALL stay in mem_bus_arbiter.

Verification
REQ-019 After reset, m_req=3'b111 with slave s_gnt and s_rvalid one cycle later, repeated -> grants in order 0,1,2,0, each transaction 3 cycles.
REQ-020 Master 1 reads 0x0000_0040 and the slave returns 0xDEAD_BEEF after 4 RESP cycles -> m_rvalid=3'b010, m_rdata=0xDEAD_BEEF, m_err=0.
REQ-021 TIMEOUT=4 with the slave silent -> m_rvalid[owner]=1 and m_err[owner]=1 on the 4th RESP cycle, m_rdata=0, busy=0 next cycle; a later s_rvalid is ignored.
REQ-022 Master 0 drops m_req in ADDR while s_gnt=0 -> return to IDLE, no m_rvalid, the next pick is unchanged.
REQ-023 rst_n pulsed low during RESP -> all outputs 0 asynchronously, state=IDLE, and the next grant goes to master 0.
REQ-024 Master 2 writes 0x1234_5678 with wstrb=4'b0011 while master 0 also requests -> s_* carries master 2's values unchanged until s_gnt, and master 0 is served next.
